hilo_muldiv_seq: RTL

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair and runs the CPU's mult/multu/div/divu/mthi/mtlo operations.
- Sits beside the ALU in the execute stage, replacing its single-cycle combinational multiply/divide path.
- Exposes `hilo_q` to the ALU for mfhi/mflo.
- Stalls the pipeline while an iterative operation is in flight.

---
 rtl/hilo_muldiv_seq_pkg.sv | 31 +++
 rtl/hilo_muldiv_seq_if.sv | 27 ++
 rtl/hilo_muldiv_seq_iter.sv | 52 +++++
 rtl/hilo_muldiv_seq.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared op and state encodings for the HI/LO multiply/divide sequencer.
package hilo_muldiv_seq_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_iter(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the HI/LO sequencer.
interface hilo_muldiv_seq_if #(parameter int XLEN = 32);
    import hilo_muldiv_seq_pkg::*;

    logic              start;
    md_op_e            op;
    logic [XLEN-1:0]   rs;
    logic [XLEN-1:0]   rt;
    logic              cancel;
    logic              rd_hilo;
    logic              ready;
    logic              busy;
    logic              stall;
    logic              done;
    logic [2*XLEN-1:0] hilo_q;

    modport master (
        output start, op, rs, rt, cancel, rd_hilo,
        input  ready, busy, stall, done, hilo_q
    );

    modport slave (
        input  start, op, rs, rt, cancel, rd_hilo,
        output ready, busy, stall, done, hilo_q
    );

endinterface

// File: rtl/hilo_muldiv_seq_iter.sv
// Radix-2 datapath: shift-add multiply into a 2*XLEN accumulator, restoring divide
// with the quotient shifting through the low half of the same accumulator.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_mode_div,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_prod,
    output logic [XLEN-1:0]   o_quo,
    output logic [XLEN-1:0]   o_rem
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN:0]     r_rem;

    logic [XLEN:0]     w_sum;
    logic [XLEN+1:0]   w_shift;
    logic [XLEN+1:0]   w_diff;

    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_rem, r_acc[XLEN-1]};
    assign w_diff  = w_shift - {2'b00, r_opnd};

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_opnd <= i_mode_div ? i_b : i_a;
            r_acc  <= {{XLEN{1'b0}}, (i_mode_div ? i_a : i_b)};
            r_rem  <= '0;
        end else if (i_step) begin
            if (!i_mode_div) begin
                r_acc <= {w_sum, r_acc[XLEN-1:1]};
            end else if (w_diff[XLEN+1]) begin
                // Borrow out: restore the shifted remainder, quotient bit 0.
                r_rem             <= w_shift[XLEN:0];
                r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], 1'b0};
            end else begin
                r_rem             <= w_diff[XLEN:0];
                r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], 1'b1};
            end
        end
    end

    assign o_prod = r_acc;
    assign o_quo  = r_acc[XLEN-1:0];
    assign o_rem  = r_rem[XLEN-1:0];

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner: mthi/mtlo in one cycle, mult/div over XLEN iterations plus a sign-fix cycle.
// Stalls a dependent or new request while busy; cancel and reset discard the in-flight op.
module hilo_muldiv_seq
    import hilo_muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_cpu,
    input  logic              reset,
    hilo_muldiv_seq_if.slave  md
);

    localparam int CW = $clog2(XLEN);

    md_state_e         r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    md_op_e            r_op;
    logic              r_neg_res, r_neg_rem, r_div0, r_done;
    logic [XLEN-1:0]   r_rs_raw, r_hi, r_lo;

    logic              w_load, w_step, w_wr_res, w_mode_div;
    logic [XLEN-1:0]   w_mag_rs, w_mag_rt, w_quo, w_rem, w_res_hi, w_res_lo;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_mag_rs   = (md_is_signed(md.op) && md.rs[XLEN-1]) ? -md.rs : md.rs;
    assign w_mag_rt   = (md_is_signed(md.op) && md.rt[XLEN-1]) ? -md.rt : md.rt;
    assign w_mode_div = w_load ? md_is_div(md.op) : md_is_div(r_op);

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk        (clk_cpu),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_mode_div (w_mode_div),
        .i_a        (w_mag_rs),
        .i_b        (w_mag_rt),
        .o_prod     (w_prod),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_wr_res    = 1'b0;
        case (r_state)
            ST_IDLE: if (md.start && md_is_iter(md.op)) begin
                w_load      = 1'b1;
                w_state_nxt = ST_CALC;
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (r_cnt == CW'(XLEN-1)) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                w_wr_res    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (md.cancel && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_step      = 1'b0;
            w_wr_res    = 1'b0;
        end
    end

    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

    always_comb begin
        w_res_hi = w_prod_fix[2*XLEN-1:XLEN];
        w_res_lo = w_prod_fix[XLEN-1:0];
        if (md_is_div(r_op)) begin
            if (r_div0) begin
                w_res_hi = r_rs_raw;
                w_res_lo = '1;
            end else begin
                w_res_lo = r_neg_res ? -w_quo : w_quo;
                w_res_hi = r_neg_rem ? -w_rem : w_rem;
            end
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= MD_MULT;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_rs_raw  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_wr_res;
            if (w_load) begin
                r_cnt     <= '0;
                r_op      <= md.op;
                r_neg_res <= md_is_signed(md.op) && (md.rs[XLEN-1] ^ md.rt[XLEN-1]);
                r_neg_rem <= md_is_signed(md.op) && md.rs[XLEN-1];
                r_div0    <= (md.rt == '0);
                r_rs_raw  <= md.rs;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == ST_IDLE) && md.start && (md.op == MD_MTHI)) r_hi <= md.rs;
            if ((r_state == ST_IDLE) && md.start && (md.op == MD_MTLO)) r_lo <= md.rs;
            if (w_wr_res) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign md.busy   = (r_state != ST_IDLE);
    assign md.ready  = ~md.busy;
    assign md.stall  = md.busy & (md.rd_hilo | md.start);
    assign md.done   = r_done;
    assign md.hilo_q = {r_hi, r_lo};

endmodule
